rob_retire_ctrl: RTL and testbench

In-order retirement and recovery controller for the 3-wide ROB. Each cycle it inspects the three oldest ROB entries and decides how many retire, within the store-queue retire budget. When a mispredicted branch retires, it sequences the pipeline recovery: squash, fetch redirect, then a dispatch hold while rename state is restored. It sits between the ROB head, the store queue, fetch and dispatch.

---
 rtl/rob_retire_ctrl_pkg.sv | 35 +++
 rtl/rob_retire_ctrl_prefix_sel.sv | 46 ++++
 rtl/rob_retire_ctrl.sv | 109 ++++++++++
 tb/tb_rob_retire_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_ctrl_pkg.sv
// Shared types for the ROB retirement controller: ROB head entry layout,
// retirement FSM states and the system-wide width macros.
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif
`ifndef SYS_ROB_ADDR_WIDTH
`define SYS_ROB_ADDR_WIDTH 5
`endif

package rob_retire_ctrl_pkg;

  localparam int XLEN         = `SYS_XLEN;
  localparam int RETIRE_WIDTH = 3;

  // One ROB entry as seen at the head of the buffer.
  typedef struct packed {
    logic            valid;
    logic            completed;
    logic            is_store;
    logic            precise_state_need;
    logic [XLEN-1:0] cs_retire_pc;
  } ROB_ENTRY_PACKET;

  typedef enum logic [1:0] {
    RS_RUN,
    RS_FLUSH,
    RS_HOLD
  } RETIRE_STATE;

  // Number of set bits in a 3-bit retire vector.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/rob_retire_ctrl_prefix_sel.sv
// Combinational retire selector: per-slot eligibility, store budget and the
// in-order prefix rule, with the mask cut after a mispredicting slot.
module retire_prefix_sel
  import rob_retire_ctrl_pkg::*;
(
  input  logic       run,
  input  logic [2:0] valid,
  input  logic [2:0] completed,
  input  logic [2:0] is_store,
  input  logic [2:0] precise_state_need,
  input  logic [1:0] sq_credits,
  output logic [2:0] retire_mask,
  output logic [1:0] retire_count,
  output logic [1:0] sq_retire_cnt,
  output logic [2:0] mispredict_sel
);

  // store_ord[i]: ordinal of slot i's store among slots 0..i (1-based)
  logic [2:0][1:0] store_ord;
  logic [2:0]      eligible;
  // chain[i]: every older slot retires and none of them cuts the mask
  logic [2:0]      chain;

  assign chain[0] = run;

  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    if (gi == 0) begin : g_first
      assign store_ord[gi] = {1'b0, is_store[gi]};
    end else begin : g_rest
      assign store_ord[gi] = store_ord[gi-1] + {1'b0, is_store[gi]};
    end

    assign eligible[gi] = valid[gi] & completed[gi] &
                          (~is_store[gi] | (store_ord[gi] <= sq_credits));
    assign retire_mask[gi] = chain[gi] & eligible[gi];

    if (gi < 2) begin : g_chain
      assign chain[gi+1] = retire_mask[gi] & ~precise_state_need[gi];
    end
  end

  assign mispredict_sel = retire_mask & precise_state_need;
  assign retire_count   = popcount3(retire_mask);
  assign sq_retire_cnt  = popcount3(retire_mask & is_store);

endmodule

// File: rtl/rob_retire_ctrl.sv
// In-order 3-wide retirement controller with mispredict recovery sequencing
// (squash + redirect, then a dispatch hold) and a retired-instruction counter.
module rob_retire_ctrl
  import rob_retire_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  ROB_ENTRY_PACKET [2:0]  head_entry,
  input  logic [1:0]             sq_retire_credits,
  output logic [2:0]             retire_mask,
  output logic [1:0]             retire_count,
  output logic [1:0]             sq_retire_cnt,
  output logic                   rb_flush,
  output logic                   fch_rec_enable,
  output logic [`SYS_XLEN-1:0]   fch_rec_pc,
  output logic                   dispatch_stall,
  output logic [PERF_WIDTH-1:0]  perf_retired
);

  RETIRE_STATE           state_reg, state_next;
  logic [3:0]            hold_cnt_reg, hold_cnt_next;
  logic [XLEN-1:0]       redirect_pc_reg, redirect_pc_next;
  logic [PERF_WIDTH-1:0] perf_reg, perf_next;

  logic [2:0] valid_vec, completed_vec, store_vec, psn_vec;
  logic [2:0] mispredict_sel;
  logic       run;

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign valid_vec[gi]     = head_entry[gi].valid;
    assign completed_vec[gi] = head_entry[gi].completed;
    assign store_vec[gi]     = head_entry[gi].is_store;
    assign psn_vec[gi]       = head_entry[gi].precise_state_need;
  end

  assign run = (state_reg == RS_RUN);

  retire_prefix_sel u_prefix_sel (
    .run                (run),
    .valid              (valid_vec),
    .completed          (completed_vec),
    .is_store           (store_vec),
    .precise_state_need (psn_vec),
    .sq_credits         (sq_retire_credits),
    .retire_mask        (retire_mask),
    .retire_count       (retire_count),
    .sq_retire_cnt      (sq_retire_cnt),
    .mispredict_sel     (mispredict_sel)
  );

  // State, hold counter, redirect target and perf counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RS_RUN;
      hold_cnt_reg    <= '0;
      redirect_pc_reg <= '0;
      perf_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      redirect_pc_reg <= redirect_pc_next;
      perf_reg        <= perf_next;
    end
  end

  // Next-state logic and recovery outputs decoded from the state register.
  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    redirect_pc_next = redirect_pc_reg;
    perf_next        = perf_reg + PERF_WIDTH'(retire_count);
    rb_flush         = 1'b0;
    fch_rec_enable   = 1'b0;
    fch_rec_pc       = '0;
    dispatch_stall   = 1'b0;

    case (state_reg)
      RS_RUN: begin
        // The prefix cut guarantees at most one retiring mispredict.
        if (|mispredict_sel) begin
          state_next = RS_FLUSH;
          if (mispredict_sel[0])      redirect_pc_next = head_entry[0].cs_retire_pc;
          else if (mispredict_sel[1]) redirect_pc_next = head_entry[1].cs_retire_pc;
          else                        redirect_pc_next = head_entry[2].cs_retire_pc;
        end
      end
      RS_FLUSH: begin
        rb_flush       = 1'b1;
        fch_rec_enable = 1'b1;
        fch_rec_pc     = redirect_pc_reg;
        dispatch_stall = 1'b1;
        state_next     = RS_HOLD;
        hold_cnt_next  = 4'(HOLD_CYCLES - 1);
      end
      RS_HOLD: begin
        dispatch_stall = 1'b1;
        if (hold_cnt_reg == 4'd0) state_next = RS_RUN;
        else                      hold_cnt_next = hold_cnt_reg - 4'd1;
      end
      default: state_next = RS_RUN;
    endcase
  end

  assign perf_retired = perf_reg;

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Self-checking bench for rob_retire_ctrl: vector table for the retire mask,
// hand-written recovery/reset sequences, and a randomized run against a
// cycle-level reference model.
module tb_rob_retire_ctrl;
  import rob_retire_ctrl_pkg::*;

  localparam int HOLD = 2;
  localparam int PW   = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  ROB_ENTRY_PACKET [2:0] head;
  logic [1:0]            credits;
  logic [2:0]            retire_mask;
  logic [1:0]            retire_count;
  logic [1:0]            sq_retire_cnt;
  logic                  rb_flush;
  logic                  fch_rec_enable;
  logic [XLEN-1:0]       fch_rec_pc;
  logic                  dispatch_stall;
  logic [PW-1:0]         perf_retired;

  rob_retire_ctrl #(.HOLD_CYCLES(HOLD), .PERF_WIDTH(PW)) dut (
    .clk               (clk),
    .rst               (rst),
    .head_entry        (head),
    .sq_retire_credits (credits),
    .retire_mask       (retire_mask),
    .retire_count      (retire_count),
    .sq_retire_cnt     (sq_retire_cnt),
    .rb_flush          (rb_flush),
    .fch_rec_enable    (fch_rec_enable),
    .fch_rec_pc        (fch_rec_pc),
    .dispatch_stall    (dispatch_stall),
    .perf_retired      (perf_retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ROB_ENTRY_PACKET ent(input logic v, input logic c, input logic s,
                                          input logic p, input logic [XLEN-1:0] pc);
    ROB_ENTRY_PACKET e;
    e.valid              = v;
    e.completed          = c;
    e.is_store           = s;
    e.precise_state_need = p;
    e.cs_retire_pc       = pc;
    return e;
  endfunction

  // Reference: walk slots oldest-first, stop at the first slot that cannot go.
  function automatic void model_mask(input ROB_ENTRY_PACKET [2:0] h, input logic [1:0] cr,
                                     output logic [2:0] m, output int n, output int ns,
                                     output bit mp, output logic [XLEN-1:0] mpc);
    int stores;
    stores = 0; m = '0; n = 0; ns = 0; mp = 1'b0; mpc = '0;
    for (int i = 0; i < 3; i++) begin
      if (!(h[i].valid && h[i].completed)) break;
      if (h[i].is_store) begin
        if (stores >= int'(cr)) break;
        stores++;
        ns++;
      end
      m[i] = 1'b1;
      n++;
      if (h[i].precise_state_need) begin
        mp = 1'b1;
        mpc = h[i].cs_retire_pc;
        break;
      end
    end
  endfunction

  typedef struct {
    ROB_ENTRY_PACKET [2:0] head;
    logic [1:0]            cred;
    logic [2:0]            mask;
    logic [1:0]            cnt;
    logic [1:0]            sq;
  } vec_t;

  function automatic vec_t mkv(input ROB_ENTRY_PACKET e0, input ROB_ENTRY_PACKET e1,
                               input ROB_ENTRY_PACKET e2, input logic [1:0] cr,
                               input logic [2:0] m, input logic [1:0] c, input logic [1:0] s);
    vec_t v;
    v.head[0] = e0; v.head[1] = e1; v.head[2] = e2;
    v.cred = cr; v.mask = m; v.cnt = c; v.sq = s;
    return v;
  endfunction

  vec_t            vecs [12];
  ROB_ENTRY_PACKET a_ok, s_ok, nc, inv;
  logic [PW-1:0]   p0;

  // Randomized-run model state
  int              busy;
  logic [XLEN-1:0] m_pc;
  logic [PW-1:0]   m_perf;
  logic [2:0]      e_mask;
  int              e_n, e_ns;
  bit              e_mp;
  logic [XLEN-1:0] e_mpc;
  bit              e_flush;

  initial begin
    a_ok = ent(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    s_ok = ent(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    nc   = ent(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    inv  = '0;

    vecs[0]  = mkv(inv,  inv,  inv,  2'd3, 3'b000, 2'd0, 2'd0);
    vecs[1]  = mkv(a_ok, a_ok, a_ok, 2'd0, 3'b111, 2'd3, 2'd0);
    vecs[2]  = mkv(s_ok, s_ok, a_ok, 2'd1, 3'b001, 2'd1, 2'd1);
    vecs[3]  = mkv(s_ok, s_ok, a_ok, 2'd2, 3'b111, 2'd3, 2'd2);
    vecs[4]  = mkv(nc,   a_ok, a_ok, 2'd3, 3'b000, 2'd0, 2'd0);
    vecs[5]  = mkv(a_ok, a_ok, a_ok, 2'd3, 3'b111, 2'd3, 2'd0);
    vecs[6]  = mkv(s_ok, a_ok, a_ok, 2'd0, 3'b000, 2'd0, 2'd0);
    vecs[7]  = mkv(a_ok, inv,  a_ok, 2'd3, 3'b001, 2'd1, 2'd0);
    vecs[8]  = mkv(s_ok, s_ok, s_ok, 2'd3, 3'b111, 2'd3, 2'd3);
    vecs[9]  = mkv(s_ok, s_ok, s_ok, 2'd2, 3'b011, 2'd2, 2'd2);
    vecs[10] = mkv(a_ok, s_ok, s_ok, 2'd1, 3'b011, 2'd2, 2'd1);
    vecs[11] = mkv(a_ok, a_ok, nc,   2'd1, 3'b011, 2'd2, 2'd0);

    // Reset state
    rst = 1'b1; head = '0; credits = 2'd0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_mask",  64'(retire_mask), 64'd0);
    check("rst_flush", 64'(rb_flush), 64'd0);
    check("rst_fen",   64'(fch_rec_enable), 64'd0);
    check("rst_fpc",   64'(fch_rec_pc), 64'd0);
    check("rst_stall", 64'(dispatch_stall), 64'd0);
    check("rst_perf",  64'(perf_retired), 64'd0);
    $display("reset: mask=%b stall=%b perf=%0d", retire_mask, dispatch_stall, perf_retired);
    @(negedge clk); rst = 1'b0;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      head = vecs[i].head; credits = vecs[i].cred;
      #1;
      check("vec_mask", 64'(retire_mask), 64'(vecs[i].mask));
      check("vec_cnt",  64'(retire_count), 64'(vecs[i].cnt));
      check("vec_sq",   64'(sq_retire_cnt), 64'(vecs[i].sq));
      $display("vec %0d: cred=%0d mask=%b cnt=%0d sq=%0d", i, credits, retire_mask, retire_count, sq_retire_cnt);
    end

    // Perf counter advances by the retired count
    @(negedge clk);
    head[0] = a_ok; head[1] = a_ok; head[2] = a_ok; credits = 2'd0;
    #1;
    p0 = perf_retired;
    check("perf_mask", 64'(retire_mask), 64'b111);
    @(negedge clk); head = '0; #1;
    check("perf_inc3", 64'(perf_retired), 64'(p0 + 32'd3));
    $display("perf: before=%0d after=%0d", p0, perf_retired);

    // Mispredict in slot 1
    @(negedge clk);
    head[0] = a_ok; head[1] = ent(1'b1, 1'b1, 1'b0, 1'b1, 32'h5000); head[2] = a_ok;
    credits = 2'd3;
    #1;
    p0 = perf_retired;
    check("mp1_mask",  64'(retire_mask), 64'b011);
    check("mp1_cnt",   64'(retire_count), 64'd2);
    check("mp1_nofl",  64'(rb_flush), 64'd0);
    check("mp1_nostl", 64'(dispatch_stall), 64'd0);
    @(negedge clk);
    head[0] = a_ok; head[1] = a_ok; head[2] = a_ok;
    #1;
    check("mp1_flush", 64'(rb_flush), 64'd1);
    check("mp1_fen",   64'(fch_rec_enable), 64'd1);
    check("mp1_fpc",   64'(fch_rec_pc), 64'h5000);
    check("mp1_stl0",  64'(dispatch_stall), 64'd1);
    check("mp1_msk0",  64'(retire_mask), 64'd0);
    check("mp1_perf",  64'(perf_retired), 64'(p0 + 32'd2));
    $display("mispredict slot1: flush=%b pc=%h stall=%b", rb_flush, fch_rec_pc, dispatch_stall);
    for (int c = 1; c < 1 + HOLD; c++) begin
      @(negedge clk); #1;
      check("hold_flush", 64'(rb_flush), 64'd0);
      check("hold_fen",   64'(fch_rec_enable), 64'd0);
      check("hold_stall", 64'(dispatch_stall), 64'd1);
      check("hold_mask",  64'(retire_mask), 64'd0);
      check("hold_perf",  64'(perf_retired), 64'(p0 + 32'd2));
      $display("hold cycle %0d: stall=%b mask=%b perf=%0d", c, dispatch_stall, retire_mask, perf_retired);
    end
    @(negedge clk); #1;
    check("resume_stall", 64'(dispatch_stall), 64'd0);
    check("resume_mask",  64'(retire_mask), 64'b111);
    $display("resume: stall=%b mask=%b", dispatch_stall, retire_mask);

    // Mispredict in slot 2 behind two completed slots
    @(negedge clk);
    head[0] = a_ok; head[1] = a_ok; head[2] = ent(1'b1, 1'b1, 1'b0, 1'b1, 32'h7abc);
    #1;
    check("mp2_mask", 64'(retire_mask), 64'b111);
    @(negedge clk); head = '0; #1;
    check("mp2_flush", 64'(rb_flush), 64'd1);
    check("mp2_fpc",   64'(fch_rec_pc), 64'h7abc);
    $display("mispredict slot2: flush=%b pc=%h", rb_flush, fch_rec_pc);
    for (int c = 0; c < HOLD; c++) @(negedge clk);
    @(negedge clk); #1;
    check("mp2_resume", 64'(dispatch_stall), 64'd0);

    // Asynchronous reset in the middle of HOLD
    @(negedge clk);
    head[0] = ent(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234); head[1] = a_ok; head[2] = a_ok;
    #1;
    check("rh_mask", 64'(retire_mask), 64'b001);
    @(negedge clk); head = '0;
    @(negedge clk); #1;
    check("rh_inhold", 64'(dispatch_stall), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rh_stall", 64'(dispatch_stall), 64'd0);
    check("rh_flush", 64'(rb_flush), 64'd0);
    check("rh_fpc",   64'(fch_rec_pc), 64'd0);
    check("rh_perf",  64'(perf_retired), 64'd0);
    check("rh_mask0", 64'(retire_mask), 64'd0);
    $display("reset mid-hold: stall=%b perf=%0d", dispatch_stall, perf_retired);
    @(negedge clk); rst = 1'b0;
    head[0] = a_ok; head[1] = a_ok; head[2] = a_ok;
    #1;
    check("rh_run_mask", 64'(retire_mask), 64'b111);
    @(negedge clk); head = '0; #1;
    check("rh_run_perf", 64'(perf_retired), 64'd3);

    // Randomized run against the reference model
    @(negedge clk); rst = 1'b1; head = '0;
    @(negedge clk); rst = 1'b0;
    busy = 0; m_pc = '0; m_perf = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        head[i] = ent(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom);
      end
      credits = 2'($urandom_range(0, 3));
      #1;
      if (busy == 0) begin
        model_mask(head, credits, e_mask, e_n, e_ns, e_mp, e_mpc);
        e_flush = 1'b0;
      end else begin
        e_mask = '0; e_n = 0; e_ns = 0; e_mp = 1'b0; e_mpc = '0;
        e_flush = (busy == HOLD + 1);
      end
      check("rnd_mask",  64'(retire_mask), 64'(e_mask));
      check("rnd_cnt",   64'(retire_count), 64'(e_n));
      check("rnd_sq",    64'(sq_retire_cnt), 64'(e_ns));
      check("rnd_flush", 64'(rb_flush), 64'(e_flush));
      check("rnd_fen",   64'(fch_rec_enable), 64'(e_flush));
      check("rnd_fpc",   64'(fch_rec_pc), e_flush ? 64'(m_pc) : 64'd0);
      check("rnd_stall", 64'(dispatch_stall), 64'(busy != 0));
      check("rnd_perf",  64'(perf_retired), 64'(m_perf));
      $display("rnd %0d: cred=%0d mask=%b sq=%0d flush=%b stall=%b perf=%0d",
               cyc, credits, retire_mask, sq_retire_cnt, rb_flush, dispatch_stall, perf_retired);
      m_perf = m_perf + PW'(e_n);
      if (busy > 0) busy--;
      else if (e_mp) begin
        busy = HOLD + 1;
        m_pc = e_mpc;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
